muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit for the next-generation core; adds the M extension beside the existing single-cycle ALU.
- Receives decoded funct3 and both register operands, runs a multi-cycle shift-add multiply or restoring divide, and returns a result under a start/busy/done handshake.
- The control unit stalls the PC and regfile write-back while busy_o is high.
- Width is parametrised; an optional single-cycle multiply mode is available.

Parameters:
- BITNESS, 32, operand and result width (>= 8).
- FAST_MUL, 0, 1 = MUL/MULH/MULHSU/MULHU complete via the combinational product in the fast path; 0 = iterative.

Ports:
- clk_i  input  1  clock, all state on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  request; accepted only in IDLE or DONE.
- funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a_i  input  BITNESS  rs1 value (dividend / multiplicand).
- op_b_i  input  BITNESS  rs2 value (divisor / multiplier).
- kill_i  input  1  abort the current operation (pipeline flush).
- busy_o  output  1  high in CALC and FIX.
- done_o  output  1  one-cycle pulse; result_o valid.
- result_o  output  BITNESS  result; held until the next accepted start.

Behaviour:
- Reset (sync, rst_i=1 at an edge):
  - state=IDLE, busy_o=0, done_o=0, result_o=0, internal counters/accumulators cleared.
  - Reset overrides kill_i and start_i and aborts any in-flight operation.
- States: IDLE, CALC, FIX, DONE. done_o=1 only in DONE.
- Accept: start_i=1 && kill_i=0 in IDLE or DONE at an edge.
  - Latches funct3_i, op_a_i, op_b_i; later input changes are ignored.
  - While busy_o=1, start_i is ignored.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - Signed operands are converted to magnitudes at accept; signs are recorded.
- Fast path: accept goes straight to DONE; done_o is high in the cycle after the accept edge (latency 1). Applies to:
  - Divide by zero (op_b=0): DIV/DIVU -> all ones; REM/REMU -> op_a.
  - Signed overflow (DIV/REM with op_a=1<<(BITNESS-1), op_b=all ones): DIV -> op_a; REM -> 0.
  - Any multiply when FAST_MUL=1.
- Normal path: accept -> CALC, iteration counter = BITNESS-1.
  - Multiply: 2*BITNESS-bit accumulator; one multiplier bit per cycle, LSB first, shift-add on magnitudes.
  - Divide: restoring; one quotient bit per cycle, MSB first; remainder BITNESS+1 bits.
  - CALC runs exactly BITNESS edges, counter decrements each edge; at counter=0 -> FIX.
  - FIX (one edge):
    - Negate the product if the operand signs differ.
    - Negate the quotient if the signs differ; the remainder takes the dividend sign.
    - Select the low half (MUL) or high half (MULH*), or quotient/remainder. Write result_o. -> DONE.
  - Latency: accept edge = edge 1; done_o high after edge BITNESS+2 (34 for BITNESS=32).
- DONE lasts one cycle, then -> IDLE, or -> CALC / DONE if a new start is accepted in that same cycle (back-to-back issue).
- kill_i=1 at an edge in CALC/FIX/DONE:
  - Next state IDLE, no done_o pulse, result_o keeps its previous value.
  - kill_i with start_i in the same cycle: start is discarded.
- Width rules:
  - Results are truncated to BITNESS.
  - Negation is two's complement within the working width.
  - The most-negative magnitude (1<<(BITNESS-1)) must be handled without overflow; internal magnitudes carry one extra bit.

Test Plan (BITNESS=32, FAST_MUL=0 unless stated):
- MUL 7 * 0xFFFFFFFD -> result_o=0xFFFFFFEB; done_o pulses after edge 34; busy_o high for exactly 33 cycles.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. Repeat with FAST_MUL=1: same values, done_o after edge 1.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, done_o after edge 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, latency 1.
- Handshake and abort:
  - kill_i on the 10th CALC cycle -> busy_o=0 next cycle, no done_o, result_o unchanged.
  - start_i pulsed while busy -> ignored.
  - New start in the DONE cycle -> accepted; second result correct.
- rst_i asserted mid-CALC -> after that edge busy_o=0, done_o=0, result_o=0. A following MUL 3*4 -> 12.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// start/busy/done handshake with kill and an optional single-cycle multiply.
module muldiv_unit #(
    parameter int BITNESS  = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [2:0]         funct3_i,
    input  logic [BITNESS-1:0] op_a_i,
    input  logic [BITNESS-1:0] op_b_i,
    input  logic               kill_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [BITNESS-1:0] result_o
);
    localparam int W  = BITNESS;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2:0]      funct3;
    logic [W-1:0]    hi;
    logic [W-1:0]    lo;
    logic [W-1:0]    mcand;
    logic            sign_a;
    logic            sign_b;

    logic            a_signed;
    logic            b_signed;
    logic            in_sign_a;
    logic            in_sign_b;
    logic [W-1:0]    in_mag_a;
    logic [W-1:0]    in_mag_b;
    logic            div_overflow;
    logic [2*W-1:0]  ext_a;
    logic [2*W-1:0]  ext_b;
    logic [2*W-1:0]  fast_product;
    logic            take_fast;
    logic [W-1:0]    fast_result;

    // Operand signedness is decided at accept; magnitudes are unsigned W-bit,
    // so the most-negative value maps to 1<<(W-1) without overflow.
    assign a_signed     = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
    assign b_signed     = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];
    assign in_sign_a    = a_signed & op_a_i[W-1];
    assign in_sign_b    = b_signed & op_b_i[W-1];
    assign in_mag_a     = in_sign_a ? -op_a_i : op_a_i;
    assign in_mag_b     = in_sign_b ? -op_b_i : op_b_i;
    assign div_overflow = ~funct3_i[0] & (op_a_i == MOST_NEG) & (op_b_i == '1);
    assign ext_a        = {{W{in_sign_a}}, op_a_i};
    assign ext_b        = {{W{in_sign_b}}, op_b_i};
    assign fast_product = ext_a * ext_b;

    always_comb begin
        take_fast   = 1'b0;
        fast_result = '0;
        if (funct3_i[2]) begin
            if (op_b_i == '0) begin
                take_fast   = 1'b1;
                fast_result = funct3_i[1] ? op_a_i : '1;
            end else if (div_overflow) begin
                take_fast   = 1'b1;
                fast_result = funct3_i[1] ? '0 : op_a_i;
            end
        end else if (FAST_MUL) begin
            take_fast   = 1'b1;
            fast_result = (funct3_i[1:0] == 2'b00) ? fast_product[W-1:0]
                                                   : fast_product[2*W-1:W];
        end
    end

    logic [W:0]      mul_sum;
    logic [W:0]      div_shift;
    logic [W:0]      div_diff;
    logic            div_ge;

    // Multiply: hi accumulates, lo holds the multiplier shifting out LSB first.
    // Divide: lo holds the dividend shifting out MSB first, quotient shifts in.
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    assign div_shift = {hi, lo[W-1]};
    assign div_diff  = div_shift - {1'b0, mcand};
    assign div_ge    = ~div_diff[W];

    logic [2*W-1:0]  product;
    logic [2*W-1:0]  product_signed;
    logic [W-1:0]    quot;
    logic [W-1:0]    remd;
    logic [W-1:0]    fix_result;

    assign product        = {hi, lo};
    assign product_signed = (sign_a ^ sign_b) ? -product : product;
    assign quot           = (sign_a ^ sign_b) ? -lo : lo;
    assign remd           = sign_a ? -hi : hi;

    always_comb begin
        fix_result = '0;
        case (funct3)
            3'b000:                 fix_result = product_signed[W-1:0];
            3'b001, 3'b010, 3'b011: fix_result = product_signed[2*W-1:W];
            3'b100, 3'b101:         fix_result = quot;
            default:                fix_result = remd;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            count    <= '0;
            funct3   <= '0;
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i && !kill_i) begin
                        funct3 <= funct3_i;
                        sign_a <= in_sign_a;
                        sign_b <= in_sign_b;
                        count  <= CW'(W - 1);
                        hi     <= '0;
                        lo     <= funct3_i[2] ? in_mag_a : in_mag_b;
                        mcand  <= funct3_i[2] ? in_mag_b : in_mag_a;
                        if (take_fast) begin
                            state    <= DONE;
                            busy_o   <= 1'b0;
                            done_o   <= 1'b1;
                            result_o <= fast_result;
                        end else begin
                            state    <= CALC;
                            busy_o   <= 1'b1;
                            done_o   <= 1'b0;
                        end
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b0;
                    end
                end
                CALC: begin
                    if (kill_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        if (funct3[2]) begin
                            hi <= div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
                            lo <= {lo[W-2:0], div_ge};
                        end else begin
                            hi <= mul_sum[W:1];
                            lo <= {mul_sum[0], lo[W-1:1]};
                        end
                        count <= count - CW'(1);
                        if (count == '0) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (kill_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        state    <= DONE;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        result_o <= fix_result;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: iterative and fast-multiply instances driven in
// lockstep, checked every cycle against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy_s, done_s, busy_f, done_f;
    logic [31:0] res_s, res_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.BITNESS(W), .FAST_MUL(1'b0)) dut_slow (
        .clk_i(clk), .rst_i(rst), .start_i(start), .funct3_i(funct3),
        .op_a_i(op_a), .op_b_i(op_b), .kill_i(kill),
        .busy_o(busy_s), .done_o(done_s), .result_o(res_s)
    );

    muldiv_unit #(.BITNESS(W), .FAST_MUL(1'b1)) dut_fast (
        .clk_i(clk), .rst_i(rst), .start_i(start), .funct3_i(funct3),
        .op_a_i(op_a), .op_b_i(op_b), .kill_i(kill),
        .busy_o(busy_f), .done_o(done_f), .result_o(res_f)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // RISC-V M-extension semantics computed with wide plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [127:0] ea, eb, p;
        longint       da, db, q, r;
        bit           a_sgn, b_sgn;
        a_sgn = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
        b_sgn = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
        if (!f3[2]) begin
            ea = a_sgn ? {{96{a[31]}}, a} : {96'd0, a};
            eb = b_sgn ? {{96{b[31]}}, b} : {96'd0, b};
            p  = ea * eb;
            return (f3 == 3'd0) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (a_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : a;
        da = a_sgn ? {{32{a[31]}}, a} : {32'd0, a};
        db = b_sgn ? {{32{b[31]}}, b} : {32'd0, b};
        q  = da / db;
        r  = da % db;
        return f3[1] ? 32'(r) : 32'(q);
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b, input bit fast_mul);
        if (!f3[2]) return fast_mul;
        return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Timing model per instance: 0 idle, 1 busy, 2 done-pulse cycle.
    int          phase[2];
    int          remain[2];
    logic [31:0] pend[2];
    logic [31:0] exp_res[2];
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                phase[i]   = 0;
                remain[i]  = 0;
                exp_res[i] = 32'd0;
            end else if (phase[i] == 1) begin
                if (kill) begin
                    phase[i] = 0;
                end else begin
                    remain[i]--;
                    if (remain[i] == 0) begin
                        phase[i]   = 2;
                        exp_res[i] = pend[i];
                    end
                end
            end else if (start && !kill) begin
                pend[i] = ref_result(funct3, op_a, op_b);
                if (is_fast(funct3, op_a, op_b, i == 1)) begin
                    phase[i]   = 2;
                    exp_res[i] = pend[i];
                end else begin
                    phase[i]  = 1;
                    remain[i] = W + 1;
                end
            end else begin
                phase[i] = 0;
            end
        end
        if (rst) model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("cmp_busy_slow", {31'd0, busy_s}, {31'd0, phase[0] == 1});
            check("cmp_done_slow", {31'd0, done_s}, {31'd0, phase[0] == 2});
            check("cmp_res_slow", res_s, exp_res[0]);
            check("cmp_busy_fast", {31'd0, busy_f}, {31'd0, phase[1] == 1});
            check("cmp_done_fast", {31'd0, done_f}, {31'd0, phase[1] == 2});
            check("cmp_res_fast", res_f, exp_res[1]);
        end
    end

    // One transaction with latency/busy measurement; poke>0 pulses a stray start while busy.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat_slow,
                          input int lat_fast, input int poke);
        int edges, lat_s, lat_f, busy_cnt;
        @(negedge clk);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        edges = 0; lat_s = -1; lat_f = -1; busy_cnt = 0;
        while (lat_s < 0 && edges < 60) begin
            @(negedge clk);
            edges++;
            if (edges == 1) begin
                start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
            end
            if (poke > 0 && edges == poke) begin
                start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4;
            end
            if (poke > 0 && edges == poke + 1) start = 1'b0;
            if (busy_s) busy_cnt++;
            if (done_s && lat_s < 0) lat_s = edges;
            if (done_f && lat_f < 0) lat_f = edges;
        end
        check({name, "_lat_slow"}, lat_s, lat_slow);
        check({name, "_lat_fast"}, lat_f, lat_fast);
        check({name, "_busy_cycles"}, busy_cnt, lat_slow - 1);
        check({name, "_res_slow"}, res_s, exp);
        check({name, "_res_fast"}, res_f, exp);
    endtask

    task automatic kill_test();
        int edges, pulses;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; op_a = 32'h1234_5678; op_b = 32'd3;
        for (edges = 1; edges <= 11; edges++) begin
            @(negedge clk);
            if (edges == 1) start = 1'b0;
            if (edges == 10) kill = 1'b1;
            if (edges == 11) kill = 1'b0;
        end
        check("kill_busy_slow", {31'd0, busy_s}, 32'd0);
        check("kill_busy_fast", {31'd0, busy_f}, 32'd0);
        check("kill_res_slow", res_s, 32'd2);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_s || done_f) pulses++;
        end
        check("kill_no_done", pulses, 0);
    endtask

    task automatic back_to_back();
        int edges;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
        edges = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done_s && edges < 60) begin
            @(negedge clk);
            edges++;
        end
        check("b2b_first_res", res_s, 32'hFFFF_FFFD);
        start = 1'b1; funct3 = 3'b110;
        edges = 0;
        @(negedge clk);
        edges++;
        start = 1'b0;
        while (!done_s && edges < 60) begin
            @(negedge clk);
            edges++;
        end
        check("b2b_second_lat", edges, 34);
        check("b2b_second_res", res_s, 32'hFFFF_FFFF);
    endtask

    task automatic reset_test();
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd12345; op_b = 32'd678;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            if (e == 1) start = 1'b0;
            if (e == 5) rst = 1'b1;
            if (e == 6) rst = 1'b0;
        end
        check("rst_busy", {31'd0, busy_s}, 32'd0);
        check("rst_done", {31'd0, done_s}, 32'd0);
        check("rst_res_slow", res_s, 32'd0);
        check("rst_res_fast", res_f, 32'd0);
        run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 34, 1, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom % 7)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy_s}, 32'd0);
        check("reset_done", {31'd0, done_s}, 32'd0);
        check("reset_res", res_s, 32'd0);
        rst = 1'b0;

        check("model_mul", ref_result(3'b000, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("model_mulh", ref_result(3'b001, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        check("model_mulhu", ref_result(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("model_mulhsu", ref_result(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("model_div", ref_result(3'b100, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("model_rem", ref_result(3'b110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("model_divu", ref_result(3'b101, 32'hFFFF_FFFF, 32'h10), 32'h0FFF_FFFF);
        check("model_remu", ref_result(3'b111, 32'd100, 32'd7), 32'd2);
        check("model_div_ovf", ref_result(3'b100, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("model_rem_zero", ref_result(3'b110, 32'd5, 32'd0), 32'd5);

        run_op("mul_neg", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1, 0);
        run_op("mulh_minmin", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1, 0);
        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1, 0);
        run_op("mulhsu_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1, 0);
        run_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 34, 0);
        run_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 34, 0);
        run_op("divu_ignore", 3'b101, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34, 34, 5);
        run_op("divu_zero", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1, 0);
        run_op("rem_zero", 3'b110, 32'd5, 32'd0, 32'd5, 1, 1, 0);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, 0);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1, 0);
        run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34, 34, 0);
        kill_test();
        back_to_back();
        reset_test();

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start  = ($urandom % 3) == 0;
            kill   = ($urandom % 30) == 0;
            rst    = ($urandom % 700) == 0;
            funct3 = 3'($urandom);
            op_a   = pick_operand();
            op_b   = pick_operand();
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; kill = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
